// File: rtl/fetch_defs.sv
// Shared constants and FSM state type for the instruction fetch stage.
package fetch_defs;

  localparam int DEFAULT_PC_W    = 33;
  localparam int DEFAULT_INSTR_W = 32;
  localparam logic [DEFAULT_PC_W-1:0] DEFAULT_RESET_PC = '0;
  localparam int PC_INCR         = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue: synchronous FIFO with a flush that wins over push/pop.
module fetch_queue #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity lives in count, and the
  // head is masked to zero while empty so nothing stale is ever visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/request FSM, branch epoch tracking and the decode queue.
module fetch_unit
  import fetch_defs::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter int              INSTR_W  = DEFAULT_INSTR_W,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_valid,
  input  logic [PC_W-1:0]    branch_address,
  output logic               icache_req,
  output logic [PC_W-1:0]    icache_addr,
  input  logic               icache_ready,
  input  logic               icache_rdata_valid,
  input  logic [INSTR_W-1:0] icache_rdata,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [INSTR_W-1:0] deq_instr,
  output logic [PC_W-1:0]    deq_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e        state;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     req_pc;
  logic                req_epoch;
  logic                epoch;
  logic [PC_W-1:0]     branch_target;
  logic                issue_ok;
  logic                resp_enq;
  logic [CNT_W-1:0]    q_count;
  logic                q_empty;
  logic                q_full;
  logic [INSTR_W+PC_W-1:0] q_head;

  assign branch_target = branch_address & ~PC_W'(3);
  assign issue_ok      = (int'(q_count) + 1 <= DEPTH) && !branch_valid;
  assign resp_enq      = (state == S_WAIT) && icache_rdata_valid &&
                         (req_epoch == epoch) && !branch_valid;
  assign icache_addr   = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      req_pc     <= '0;
      req_epoch  <= 1'b0;
      epoch      <= 1'b0;
      icache_req <= 1'b0;
    end else if (branch_valid) begin
      pc         <= branch_target;
      epoch      <= ~epoch;
      icache_req <= 1'b0;
      // Tag any in-flight request with the pre-branch epoch so it can never
      // match again, even after an even number of back-to-back branches.
      req_epoch  <= epoch;
      case (state)
        S_REQ: begin
          if (icache_ready) begin
            req_pc <= pc;
            state  <= S_WAIT;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_WAIT:  if (icache_rdata_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_ok) begin
            icache_req <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (icache_ready) begin
            req_pc     <= pc;
            req_epoch  <= epoch;
            pc         <= pc + PC_W'(PC_INCR);
            icache_req <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT:  if (icache_rdata_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .WIDTH (INSTR_W + PC_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_enq && !q_full),
    .push_data ({icache_rdata, req_pc}),
    .pop       (deq_valid && deq_ready),
    .flush     (branch_valid),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign deq_valid = !q_empty;
  assign deq_instr = q_head[INSTR_W+PC_W-1:PC_W];
  assign deq_pc    = q_head[PC_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, stalls, branches, wrap, reset.
module tb_fetch_unit;

  localparam int PC_W    = 33;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               branch_valid;
  logic [PC_W-1:0]    branch_address;
  logic               icache_req;
  logic [PC_W-1:0]    icache_addr;
  logic               icache_ready;
  logic               icache_rdata_valid;
  logic [INSTR_W-1:0] icache_rdata;
  logic               deq_valid;
  logic               deq_ready;
  logic [INSTR_W-1:0] deq_instr;
  logic [PC_W-1:0]    deq_pc;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .branch_valid       (branch_valid),
    .branch_address     (branch_address),
    .icache_req         (icache_req),
    .icache_addr        (icache_addr),
    .icache_ready       (icache_ready),
    .icache_rdata_valid (icache_rdata_valid),
    .icache_rdata       (icache_rdata),
    .deq_valid          (deq_valid),
    .deq_ready          (deq_ready),
    .deq_instr          (deq_instr),
    .deq_pc             (deq_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
    return 32'h5A00_0000 ^ a[31:0];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!icache_req && n < 20) begin
      tick();
      n++;
    end
    if (!icache_req) check("req_timeout", {63'd0, icache_req}, 64'd1);
  endtask

  // Full request/response for one word; returns cycles spent waiting for req.
  task automatic fetch_one(input logic [PC_W-1:0] addr, input int lat, output int n);
    wait_req(n);
    check("fetch_addr", icache_addr, addr);
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    check("req_drop_after_accept", icache_req, 0);
    repeat (lat - 1) tick();
    icache_rdata_valid = 1'b1;
    icache_rdata       = instr_of(addr);
    tick();
    icache_rdata_valid = 1'b0;
  endtask

  task automatic check_head(input logic [PC_W-1:0] addr);
    check("head_valid", deq_valid, 1);
    check("head_pc", deq_pc, addr);
    check("head_instr", deq_instr, instr_of(addr));
  endtask

  task automatic branch_to(input logic [PC_W-1:0] target, input logic accept);
    branch_valid   = 1'b1;
    branch_address = target;
    icache_ready   = accept;
    tick();
    branch_valid = 1'b0;
    icache_ready = 1'b0;
  endtask

  task automatic stale_response(input logic [PC_W-1:0] addr);
    icache_rdata_valid = 1'b1;
    icache_rdata       = instr_of(addr);
    tick();
    icache_rdata_valid = 1'b0;
    check("stale_dropped", deq_valid, 0);
  endtask

  initial begin
    int n;
    rst_n              = 1'b0;
    branch_valid       = 1'b0;
    branch_address     = '0;
    icache_ready       = 1'b0;
    icache_rdata_valid = 1'b0;
    icache_rdata       = '0;
    deq_ready          = 1'b1;
    repeat (2) tick();

    check("rst_req", icache_req, 0);
    check("rst_addr", icache_addr, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_deq_instr", deq_instr, 0);
    check("rst_deq_pc", deq_pc, 0);
    rst_n = 1'b1;

    // Sequential stream, 1-cycle latency, decode always ready.
    for (int i = 0; i < 4; i++) begin
      fetch_one(PC_W'(4 * i), 1, n);
      check("issue_gap", n, 1);
      check_head(PC_W'(4 * i));
    end

    // Backpressure: fill the queue, verify fetch stalls, then one pop frees one slot.
    tick();
    deq_ready = 1'b0;
    fetch_one(PC_W'(16), 2, n);
    fetch_one(PC_W'(20), 1, n);
    fetch_one(PC_W'(24), 3, n);
    fetch_one(PC_W'(28), 1, n);
    check_head(PC_W'(16));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_req", icache_req, 0);
    end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check_head(PC_W'(20));
    fetch_one(PC_W'(32), 1, n);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("refull_no_req", icache_req, 0);
    end
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", deq_pc, PC_W'(20 + 4 * i));
      tick();
    end
    check("drained", deq_valid, 0);

    // Cache stall: request and address hold until accepted.
    wait_req(n);
    for (int i = 0; i < 5; i++) begin
      check("stall_req", icache_req, 1);
      check("stall_addr", icache_addr, 36);
      tick();
    end
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    check("post_accept_req", icache_req, 0);
    check("post_accept_pc", icache_addr, 40);
    icache_rdata_valid = 1'b1;
    icache_rdata       = instr_of(PC_W'(36));
    tick();
    icache_rdata_valid = 1'b0;
    check_head(PC_W'(36));

    // Branch while a request is outstanding and the queue holds entries.
    deq_ready = 1'b0;
    fetch_one(PC_W'(40), 1, n);
    wait_req(n);
    check("pre_branch_addr", icache_addr, 44);
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    check("pre_branch_queue", deq_valid, 1);
    branch_to(PC_W'(64), 1'b0);
    check("flush_empty", deq_valid, 0);
    check("branch_pc", icache_addr, 64);
    stale_response(PC_W'(44));
    deq_ready = 1'b1;
    fetch_one(PC_W'(64), 1, n);
    check_head(PC_W'(64));

    // Misaligned target is word-aligned.
    wait_req(n);
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    branch_to(PC_W'(67), 1'b0);
    check("align_pc", icache_addr, 64);
    stale_response(PC_W'(68));
    fetch_one(PC_W'(64), 1, n);
    check_head(PC_W'(64));

    // Branch cancels an unaccepted request.
    wait_req(n);
    check("req_before_cancel", icache_addr, 68);
    branch_to(PC_W'(128), 1'b0);
    check("cancel_req", icache_req, 0);
    check("cancel_pc", icache_addr, 128);

    // Branch coinciding with accept, then a second branch one cycle later.
    wait_req(n);
    check("coincide_addr", icache_addr, 128);
    branch_to(PC_W'(192), 1'b1);
    check("coincide_req", icache_req, 0);
    branch_to(PC_W'(256), 1'b0);
    check("second_branch_pc", icache_addr, 256);
    stale_response(PC_W'(128));
    fetch_one(PC_W'(256), 1, n);
    check_head(PC_W'(256));

    // PC wrap from the top word to zero.
    wait_req(n);
    branch_to({{(PC_W-2){1'b1}}, 2'b00}, 1'b0);
    fetch_one({{(PC_W-2){1'b1}}, 2'b00}, 1, n);
    check_head({{(PC_W-2){1'b1}}, 2'b00});
    deq_ready = 1'b0;
    wait_req(n);
    check("wrap_addr", icache_addr, 0);
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    check("wait_queue_nonempty", deq_valid, 1);

    // Asynchronous reset mid-WAIT, then a late response must be ignored.
    rst_n = 1'b0;
    #1;
    check("async_rst_req", icache_req, 0);
    check("async_rst_addr", icache_addr, 0);
    check("async_rst_deq_valid", deq_valid, 0);
    check("async_rst_deq_pc", deq_pc, 0);
    check("async_rst_deq_instr", deq_instr, 0);
    tick();
    rst_n              = 1'b1;
    icache_rdata_valid = 1'b1;
    icache_rdata       = instr_of('0);
    tick();
    icache_rdata_valid = 1'b0;
    check("late_resp_ignored", deq_valid, 0);
    wait_req(n);
    check("post_rst_addr", icache_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
